// File: rtl/host_cmd_tx.sv
// rtl/host_cmd_tx.sv - command-to-UART-frame serializer driving RX_IN; optional inter-byte gap via HOST_CMD_TX_GAP_EN
module host_cmd_tx #(
  parameter int FRAME_WIDTH    = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic [1:0]                CMD_TYPE,
  input  logic [FRAME_WIDTH-1:0]    CMD_ADDR,
  input  logic [FRAME_WIDTH-1:0]    CMD_DATA_A,
  input  logic [FRAME_WIDTH-1:0]    CMD_DATA_B,
  input  logic [FRAME_WIDTH-1:0]    CMD_FUNC,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_SER,
  output logic                      BUSY,
  output logic                      FRAME_DONE,
  output logic                      CMD_DONE
);

  localparam int BIT_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;

  localparam logic [FRAME_WIDTH-1:0] HDR_WR  = FRAME_WIDTH'(8'hAA);
  localparam logic [FRAME_WIDTH-1:0] HDR_RD  = FRAME_WIDTH'(8'hBB);
  localparam logic [FRAME_WIDTH-1:0] HDR_ALU = FRAME_WIDTH'(8'hCC);
  localparam logic [FRAME_WIDTH-1:0] HDR_FN  = FRAME_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
`ifdef HOST_CMD_TX_GAP_EN
    ,
    S_GAP    = 3'd5
`endif
  } state_t;

  state_t                    state_q, state_n;
  logic [PRESCALE_WIDTH-1:0] cnt_q;
  logic [BIT_W-1:0]          bit_q, bit_n;
  logic [1:0]                byte_q, byte_n;

  // Command context captured at accept; the live inputs are ignored afterwards
  logic [1:0]                type_q;
  logic [FRAME_WIDTH-1:0]    addr_q, data_a_q, data_b_q, func_q;
  logic                      par_en_q, par_typ_q;
  logic [PRESCALE_WIDTH-1:0] p_q;

  logic                      accept;
  logic                      bit_end;
  logic                      last_byte;
  logic [1:0]                last_idx;
  logic [FRAME_WIDTH-1:0]    cur_byte;

  logic tx_d, busy_d, ready_d, frame_done_d, cmd_done_d;

  assign accept  = CMD_VALID && CMD_READY;
  assign bit_end = (cnt_q == p_q - PRESCALE_WIDTH'(1));

  // Index of the final byte for the latched command type
  always_comb begin
    last_idx = 2'd1;
    case (type_q)
      2'd0:    last_idx = 2'd2;
      2'd1:    last_idx = 2'd1;
      2'd2:    last_idx = 2'd3;
      default: last_idx = 2'd1;
    endcase
  end

  assign last_byte = (byte_q == last_idx);

  // Byte selected by the upcoming byte index, so the registered TX bit lines up with the state it enters
  always_comb begin
    cur_byte = HDR_FN;
    case (type_q)
      2'd0: begin
        case (byte_n)
          2'd0:    cur_byte = HDR_WR;
          2'd1:    cur_byte = addr_q;
          default: cur_byte = data_a_q;
        endcase
      end
      2'd1: begin
        cur_byte = (byte_n == 2'd0) ? HDR_RD : addr_q;
      end
      2'd2: begin
        case (byte_n)
          2'd0:    cur_byte = HDR_ALU;
          2'd1:    cur_byte = data_a_q;
          2'd2:    cur_byte = data_b_q;
          default: cur_byte = func_q;
        endcase
      end
      default: begin
        cur_byte = (byte_n == 2'd0) ? HDR_FN : func_q;
      end
    endcase
  end

  // FSM state register with bit-period counter and bit/byte indices
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_n;
      bit_q   <= bit_n;
      byte_q  <= byte_n;
      if (state_q == S_IDLE || bit_end) cnt_q <= '0;
      else                              cnt_q <= cnt_q + PRESCALE_WIDTH'(1);
    end
  end

  // Next-state logic: each non-idle state lasts exactly one latched bit period
  always_comb begin
    state_n = state_q;
    bit_n   = bit_q;
    byte_n  = byte_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_n = S_START;
          bit_n   = '0;
          byte_n  = 2'd0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          bit_n   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(FRAME_WIDTH - 1)) state_n = par_en_q ? S_PARITY : S_STOP;
          else                                  bit_n   = bit_q + BIT_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) state_n = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (last_byte) begin
            state_n = S_IDLE;
          end else begin
            byte_n  = byte_q + 2'd1;
`ifdef HOST_CMD_TX_GAP_EN
            state_n = S_GAP;
`else
            state_n = S_START;
`endif
          end
        end
      end
`ifdef HOST_CMD_TX_GAP_EN
      S_GAP: begin
        if (bit_end) state_n = S_START;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // Output decode from the next state, registered below so every output comes straight off a flop
  always_comb begin
    tx_d = 1'b1;
    case (state_n)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_byte[bit_n];
      S_PARITY: tx_d = (^cur_byte) ^ par_typ_q;
      default:  tx_d = 1'b1;
    endcase
    busy_d       = (state_n != S_IDLE);
    ready_d      = (state_n == S_IDLE);
    frame_done_d = (state_q == S_STOP) && bit_end;
    cmd_done_d   = (state_q == S_STOP) && bit_end && last_byte;
  end

  // Output registers; reset drives the line idle-high without waiting for a clock
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TX_SER     <= 1'b1;
      CMD_READY  <= 1'b1;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
      CMD_DONE   <= 1'b0;
    end else begin
      TX_SER     <= tx_d;
      CMD_READY  <= ready_d;
      BUSY       <= busy_d;
      FRAME_DONE <= frame_done_d;
      CMD_DONE   <= cmd_done_d;
    end
  end

  // Capture command fields and line settings on accept; a zero prescale is promoted to one
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      type_q    <= '0;
      addr_q    <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      func_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      p_q       <= PRESCALE_WIDTH'(1);
    end else if (accept) begin
      type_q    <= CMD_TYPE;
      addr_q    <= CMD_ADDR;
      data_a_q  <= CMD_DATA_A;
      data_b_q  <= CMD_DATA_B;
      func_q    <= CMD_FUNC;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
      p_q       <= (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;
    end
  end

endmodule

// File: tb/tb_host_cmd_tx.sv
// tb/tb_host_cmd_tx.sv - self-checking bench for host_cmd_tx
module tb_host_cmd_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_TYPE;
  logic [7:0] CMD_ADDR, CMD_DATA_A, CMD_DATA_B, CMD_FUNC;
  logic       PAR_EN, PAR_TYP;
  logic [5:0] PRESCALE;
  logic       TX_SER, BUSY, FRAME_DONE, CMD_DONE;

  int n_pass  = 0;
  int n_total = 0;

  bit exp_tx[$];
  bit exp_fd[$];
  bit pend_fd;

  host_cmd_tx #(.FRAME_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR),
    .CMD_DATA_A(CMD_DATA_A), .CMD_DATA_B(CMD_DATA_B), .CMD_FUNC(CMD_FUNC),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .PRESCALE(PRESCALE),
    .TX_SER(TX_SER), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .CMD_DONE(CMD_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void push_bit(input bit v);
    exp_tx.push_back(v);
    exp_fd.push_back(pend_fd);
    pend_fd = 1'b0;
  endfunction

  // Reference: expected line level per cycle, starting with the cycle after accept
  function automatic void build(input logic [1:0] t, input logic [7:0] ad, a, b, f,
                                input bit pe, input bit pt, input int p_in);
    logic [7:0] bytes[$];
    int p;
    bit par;
    p = (p_in == 0) ? 1 : p_in;
    exp_tx.delete();
    exp_fd.delete();
    pend_fd = 1'b0;
    case (t)
      2'd0: bytes = '{8'hAA, ad, a};
      2'd1: bytes = '{8'hBB, ad};
      2'd2: bytes = '{8'hCC, a, b, f};
      default: bytes = '{8'hDD, f};
    endcase
    for (int i = 0; i < bytes.size(); i++) begin
`ifdef HOST_CMD_TX_GAP_EN
      if (i > 0) for (int c = 0; c < p; c++) push_bit(1'b1);
`endif
      for (int c = 0; c < p; c++) push_bit(1'b0);
      par = pt;
      for (int k = 0; k < 8; k++) begin
        par = par ^ bytes[i][k];
        for (int c = 0; c < p; c++) push_bit(bytes[i][k]);
      end
      if (pe) for (int c = 0; c < p; c++) push_bit(par);
      for (int c = 0; c < p; c++) push_bit(1'b1);
      pend_fd = 1'b1;
    end
  endfunction

  // Issue one command at a negedge and check every cycle through the done cycle
  task automatic send(input logic [1:0] t, input logic [7:0] ad, a, b, f,
                      input bit pe, input bit pt, input logic [5:0] p,
                      input bit hold, input string tag);
    CMD_TYPE   = t;
    CMD_ADDR   = ad;
    CMD_DATA_A = a;
    CMD_DATA_B = b;
    CMD_FUNC   = f;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    PRESCALE   = p;
    CMD_VALID  = 1'b1;
    chk({tag, ":ready"}, CMD_READY, 1);
    build(t, ad, a, b, f, pe, pt, int'(p));
    @(posedge CLK);
    @(negedge CLK);
    if (!hold) CMD_VALID = 1'b0;
    PRESCALE   = p + 6'd4;
    PAR_EN     = ~pe;
    PAR_TYP    = ~pt;
    CMD_TYPE   = 2'($urandom);
    CMD_ADDR   = 8'($urandom);
    CMD_DATA_A = 8'($urandom);
    CMD_DATA_B = 8'($urandom);
    CMD_FUNC   = 8'($urandom);
    for (int j = 0; j < exp_tx.size(); j++) begin
      if (j > 0) @(negedge CLK);
      chk($sformatf("%s:c%0d", tag, j + 1), {TX_SER, FRAME_DONE, CMD_DONE, BUSY, CMD_READY},
          {exp_tx[j], exp_fd[j], 1'b0, 1'b1, 1'b0});
    end
    @(negedge CLK);
    chk({tag, ":done"}, {TX_SER, FRAME_DONE, CMD_DONE, BUSY, CMD_READY}, 5'b11101);
  endtask

  initial begin
    int n_done;
    RST        = 1'b0;
    CMD_VALID  = 1'b0;
    CMD_TYPE   = '0;
    CMD_ADDR   = '0;
    CMD_DATA_A = '0;
    CMD_DATA_B = '0;
    CMD_FUNC   = '0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    PRESCALE   = 6'd1;
    repeat (3) @(negedge CLK);
    chk("reset_outs", {TX_SER, FRAME_DONE, CMD_DONE, BUSY, CMD_READY}, 5'b10001);
    RST = 1'b1;
    @(negedge CLK);
    chk("idle_outs", {TX_SER, FRAME_DONE, CMD_DONE, BUSY, CMD_READY}, 5'b10001);

    send(2'd1, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 6'd4, 1'b0, "rf_read");
    send(2'd0, 8'h03, 8'h07, 8'h00, 8'h00, 1'b1, 1'b0, 6'd1, 1'b0, "rf_write_even");
    send(2'd2, 8'h00, 8'h10, 8'h20, 8'h01, 1'b1, 1'b1, 6'd2, 1'b0, "alu_odd");
    send(2'd0, 8'h5A, 8'hC3, 8'h00, 8'h00, 1'b0, 1'b0, 6'd4, 1'b0, "mid_change_a");
    send(2'd0, 8'h5A, 8'hC3, 8'h00, 8'h00, 1'b1, 1'b0, 6'd8, 1'b0, "mid_change_b");
    send(2'd3, 8'h00, 8'h00, 8'h00, 8'h81, 1'b0, 1'b0, 6'd3, 1'b1, "b2b_a");
    send(2'd3, 8'h00, 8'h00, 8'h00, 8'h7E, 1'b1, 1'b1, 6'd3, 1'b0, "b2b_b");
    send(2'd3, 8'h00, 8'h00, 8'h00, 8'h11, 1'b0, 1'b0, 6'd0, 1'b0, "p_zero");

    CMD_TYPE  = 2'd1;
    CMD_ADDR  = 8'h00;
    PAR_EN    = 1'b0;
    PRESCALE  = 6'd4;
    CMD_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    CMD_VALID = 1'b0;
    repeat (13) @(negedge CLK);
    chk("pre_reset_tx", TX_SER, 0);
    #2 RST = 1'b0;
    #1;
    chk("async_reset_tx", TX_SER, 1);
    chk("async_reset_ready", {CMD_READY, BUSY}, 2'b10);
    @(negedge CLK);
    RST = 1'b1;
    n_done = 0;
    repeat (120) begin
      @(negedge CLK);
      if (CMD_DONE) n_done++;
    end
    chk("no_done_after_reset", n_done, 0);
    send(2'd1, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 6'd2, 1'b0, "post_reset");

    for (int r = 0; r < 20; r++) begin
      send(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 6'($urandom_range(0, 6)), 1'($urandom),
           $sformatf("rnd%0d", r));
    end
    CMD_VALID = 1'b0;
    @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/host_cmd_tx.md
# host_cmd_tx

Upstream command serializer that drives the system's `RX_IN` serial input. It accepts one command per valid/ready handshake and expands it into the system's byte-level command protocol. Each byte is sent as a UART frame (start, 8 data LSB-first, optional parity, stop) at a programmable bit period. It is used as the host-side driver in system benches and as the on-chip loopback/self-test source.

## Interface
- `FRAME_WIDTH`, 8, data bits per UART frame and per command field.
- `PRESCALE_WIDTH`, 6, width of the bit-period input.
- `CLK`  in  1  single clock; all logic on rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `CMD_VALID`  in  1  command present.
- `CMD_READY`  out  1  block can accept a command.
- `CMD_TYPE`  in  2  0 = RF write, 1 = RF read, 2 = ALU with operands, 3 = ALU without operands.
- `CMD_ADDR`  in  FRAME_WIDTH  register-file address byte.
- `CMD_DATA_A`  in  FRAME_WIDTH  RF write data, or ALU operand A.
- `CMD_DATA_B`  in  FRAME_WIDTH  ALU operand B.
- `CMD_FUNC`  in  FRAME_WIDTH  ALU function byte.
- `PAR_EN`  in  1  parity bit enable.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `PRESCALE`  in  PRESCALE_WIDTH  bit period in CLK cycles; a value of 0 is treated as 1.
- `TX_SER`  out  1  serial output; idles high.
- `BUSY`  out  1  high from the cycle after accept until the command completes.
- `FRAME_DONE`  out  1  one-cycle pulse per completed byte frame.
- `CMD_DONE`  out  1  one-cycle pulse per completed command.

## Operation
- **Accept:** a command is accepted on a rising edge with `CMD_VALID && CMD_READY`.
  - At accept, the block latches all `CMD_*` fields, `PAR_EN`, `PAR_TYP` and `PRESCALE` (P).
  - Later changes to these inputs have no effect on the command in flight.
- **Byte sequences** by `CMD_TYPE`:
  - 0: 0xAA, ADDR, DATA_A (3 bytes).
  - 1: 0xBB, ADDR (2 bytes).
  - 2: 0xCC, DATA_A, DATA_B, FUNC (4 bytes).
  - 3: 0xDD, FUNC (2 bytes).
- **Frame FSM:** IDLE → START → DATA (8 bits, LSB first) → PARITY (only if latched `PAR_EN`) → STOP.
  - From STOP: go to START if bytes remain, else IDLE.
  - Every state except IDLE holds `TX_SER` for exactly P cycles, counted by the bit-period counter.
- **Parity bit:** XOR of the 8 data bits, inverted when `PAR_TYP` = 1.
- **Byte index:** a 2-bit counter that resets to 0 at accept.
  - The last byte is index `len-1`; there is no wrap-around.
- **Reset values:** `TX_SER` = 1, `CMD_READY` = 1, `BUSY` = 0, `FRAME_DONE` = 0, `CMD_DONE` = 0; FSM in IDLE; counters at 0.
- **Reset mid-frame:** reset asserted during a frame forces `TX_SER` high immediately (asynchronously). The in-flight command is dropped and no `CMD_DONE` is issued.
- `CMD_READY` = 1 only in IDLE.

## Timing
- Accept at edge k: the start bit occupies cycles k+1..k+P; `BUSY` is high from cycle k+1.
- Frame length: 10·P cycles, or 11·P with parity.
- Bytes within a command are sent back-to-back: the next start bit begins the cycle after the previous stop bit ends.
- `FRAME_DONE` is high in the first cycle after each stop bit.
- After the final stop bit, in one cycle:
  - FSM is in IDLE and `TX_SER` = 1.
  - `CMD_DONE` = 1, `BUSY` = 0 and `CMD_READY` = 1.
  - A new command can be accepted in that same cycle, giving a minimum idle gap of 1 cycle between commands.
- All outputs are registered.

## Configuration
- **`HOST_CMD_TX_GAP_EN` defined:** one extra idle bit period (P cycles, `TX_SER` = 1, state GAP) is inserted between bytes of the same command.
  - `FRAME_DONE` timing is unchanged.
  - No gap is inserted after the last byte.
- **Not defined:** the GAP state does not exist and bytes are strictly back-to-back.

## Test plan
- **RF read, no parity:** after reset, P=4, `PAR_EN`=0, type 1, ADDR=0x05.
  - `TX_SER` from cycle k+1 in 4-cycle bits: 0,1,1,0,1,1,1,0,1,1 then 0,1,0,1,0,0,0,0,0,1.
  - `CMD_DONE` in cycle k+81.
- **RF write, even parity:** P=1, `PAR_EN`=1, `PAR_TYP`=0, type 0, ADDR=0x03, DATA_A=0x07.
  - Three 11-bit frames; the parity bits are 0, 0 and 1.
  - `FRAME_DONE` three times; `CMD_DONE` at k+34.
- **Odd parity, ALU with operands:** type 2, A=0x10, B=0x20, FUNC=0x01, `PAR_TYP`=1.
  - Parity bits are 1 (0xCC), 0, 0 and 0.
  - Four frames.
- **Mid-command input change:** change `PRESCALE` from 4 to 8 and `PAR_EN` during a command.
  - Every bit of that command is still 4 cycles with the original parity setting.
  - The next command uses the new values.
- **Reset mid-frame:** assert `RST` low in the middle of the DATA bits.
  - `TX_SER` goes to 1 without waiting for a clock edge, and `CMD_READY` = 1.
  - No `CMD_DONE` is issued; a following command transmits correctly.
- **Back-to-back and gap macro:** hold `CMD_VALID` high for two type-3 commands.
  - Second start bit begins exactly 1 idle cycle after the first `CMD_DONE`.
  - With `HOST_CMD_TX_GAP_EN` defined, there are P extra high cycles between the two bytes of each command.
